// File: rtl/bus_response_collector.sv
`default_nettype none
// ============================================================================
// bus_response_collector: gathers a peripheral's done/data into one registered
// CPU response; unmapped, multi-hit and (with BUS_TIMEOUT_EN) timeout -> error.
// Revision: 1.0
// ============================================================================
module bus_response_collector #(
  parameter int          N_DEV          = 9,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_DV,
  input  logic [N_DEV-1:0]      i_sel,
  input  logic [N_DEV-1:0]      i_dev_done,
  input  logic [32*N_DEV-1:0]   i_dev_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [31:0]           o_data,
  output logic                  o_err,
  output logic [1:0]            o_err_cause
);

  localparam logic [1:0] C_CAUSE_OK       = 2'b00;
  localparam logic [1:0] C_CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] C_CAUSE_MULTI    = 2'b10;
`ifdef BUS_TIMEOUT_EN
  localparam logic [1:0] C_CAUSE_TIMEOUT  = 2'b11;
  localparam int         CNT_W            = $clog2(TIMEOUT_CYCLES);
`endif

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_DEV-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [1:0]       cause_q, cause_d;
`ifdef BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic             w_sel_any;
  logic             w_sel_multi;
  logic             w_hit;
  logic [31:0]      w_sel_data;

  // Request decode: zero bits -> unmapped, more than one bit -> multi-hit.
  always_comb begin
    w_sel_any   = |i_sel;
    w_sel_multi = (i_sel & (i_sel - N_DEV'(1))) != '0;
  end

  // Only the latched device may complete the transaction.
  always_comb begin
    w_hit      = |(i_dev_done & sel_q);
    w_sel_data = '0;
    for (int k = 0; k < N_DEV; k++) begin
      if (sel_q[k]) begin
        w_sel_data = i_dev_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_q;
    err_d   = err_q;
    cause_d = cause_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_req_DV) begin
          busy_d = 1'b1;
          if (!w_sel_any || w_sel_multi) begin
            state_d = S_RESP;
            done_d  = 1'b1;
            data_d  = ERR_DATA;
            err_d   = 1'b1;
            cause_d = w_sel_any ? C_CAUSE_MULTI : C_CAUSE_UNMAPPED;
          end else begin
            state_d = S_WAIT;
            sel_d   = i_sel;
`ifdef BUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      S_WAIT: begin
        // A completion in the final counted cycle beats the timeout.
        if (w_hit) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          data_d  = w_sel_data;
          err_d   = 1'b0;
          cause_d = C_CAUSE_OK;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_RESP;
          done_d  = 1'b1;
          data_d  = ERR_DATA;
          err_d   = 1'b1;
          cause_d = C_CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cause_q <= C_CAUSE_OK;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cause_q <= cause_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_data      = data_q;
  assign o_err       = err_q;
  assign o_err_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_response_collector.sv
`default_nettype none
// ============================================================================
// tb_bus_response_collector: randomized transactions against a per-transaction
// response model (cycle of response, data, error cause). Revision: 1.0
// ============================================================================
module tb_bus_response_collector;

  localparam int          N_DEV = 9;
  localparam int          TMO   = 16;
  localparam logic [31:0] ERR   = 32'hDEADBEEF;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 req = 1'b0;
  logic [N_DEV-1:0]     sel = '0;
  logic [N_DEV-1:0]     dev_done = '0;
  logic [32*N_DEV-1:0]  dev_data = '0;
  logic                 o_busy, o_done, o_err;
  logic [31:0]          o_data;
  logic [1:0]           o_err_cause;

  int n_checks = 0;
  int n_fail   = 0;

  bus_response_collector #(
    .N_DEV          (N_DEV),
    .TIMEOUT_CYCLES (TMO),
    .ERR_DATA       (ERR)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_DV    (req),
    .i_sel       (sel),
    .i_dev_done  (dev_done),
    .i_dev_data  (dev_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_data      (o_data),
    .o_err       (o_err),
    .o_err_cause (o_err_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_data();
    for (int k = 0; k < N_DEV; k++) dev_data[32*k +: 32] = $urandom();
  endtask

  // One transaction starting in the current cycle (cycle 0). d = cycle in
  // which the selected device pulses done, d <= 0 means never.
  task automatic run_txn(input logic [N_DEV-1:0] s, input int d,
                         input logic [31:0] dat, input bit noise);
    int          r;
    int          idx;
    logic [31:0] edata;
    logic        eerr;
    logic [1:0]  ecause;

    idx = 0;
    for (int k = 0; k < N_DEV; k++) if (s[k]) idx = k;

    if (s == '0) begin
      r = 1; edata = ERR; eerr = 1'b1; ecause = 2'b01;
    end else if ($countones(s) > 1) begin
      r = 1; edata = ERR; eerr = 1'b1; ecause = 2'b10;
    end else begin
`ifdef BUS_TIMEOUT_EN
      if (d >= 1 && d <= TMO) begin
        r = d + 1; edata = dat; eerr = 1'b0; ecause = 2'b00;
      end else begin
        r = TMO + 1; edata = ERR; eerr = 1'b1; ecause = 2'b11;
      end
`else
      r = d + 1; edata = dat; eerr = 1'b0; ecause = 2'b00;
`endif
    end

    req      = 1'b1;
    sel      = s;
    scramble_data();
    dev_done = noise ? N_DEV'($urandom()) : '0;

    for (int k = 1; k <= r + 1; k++) begin
      @(posedge clk); #1;
      check("o_done", o_done, k == r);
      check("o_busy", o_busy, k <= r);
      if (k >= r) begin
        check("o_data", o_data, edata);
        check("o_err", o_err, eerr);
        check("o_err_cause", o_err_cause, ecause);
      end
      req      = (noise && k <= r) ? 1'($urandom_range(0, 1)) : 1'b0;
      sel      = N_DEV'($urandom());
      scramble_data();
      dev_done = noise ? (N_DEV'($urandom()) & ~s) : '0;
      if (k == d) begin
        dev_done = dev_done | s;
        dev_data[32*idx +: 32] = dat;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N_DEV-1:0] s;
    int               d;
    int               wait_cycles;
    int               pick;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_data", o_data, 32'h0);
    check("rst_err", o_err, 1'b0);
    check("rst_cause", o_err_cause, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(9'h010, 3, 32'h0000_00A5, 1'b0);
    run_txn(9'h000, 0, 32'h0, 1'b0);
    run_txn(9'b000000011, 0, 32'h0, 1'b0);
    run_txn(9'h010, 1, 32'h1234_5678, 1'b1);
`ifdef BUS_TIMEOUT_EN
    run_txn(9'h002, 0, 32'h0, 1'b1);
    run_txn(9'h002, TMO, 32'hCAFE_0016, 1'b0);
    run_txn(9'h002, TMO + 1, 32'hCAFE_0017, 1'b1);
`endif

    for (int t = 0; t < 60; t++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0) begin
        s = '0;
      end else if (pick == 1) begin
        s = N_DEV'($urandom());
        while ($countones(s) < 2) s = N_DEV'($urandom());
      end else begin
        s = N_DEV'(1) << $urandom_range(0, N_DEV - 1);
      end
`ifdef BUS_TIMEOUT_EN
      d = $urandom_range(0, TMO + 4);
`else
      d = $urandom_range(1, 20);
`endif
      run_txn(s, d, $urandom(), 1'($urandom_range(0, 1)));
    end

    // Reset during WAIT; without a timeout the wait must persist indefinitely.
`ifdef BUS_TIMEOUT_EN
    wait_cycles = 4;
`else
    wait_cycles = 1000;
`endif
    req      = 1'b1;
    sel      = 9'h008;
    dev_done = '0;
    for (int k = 1; k <= wait_cycles; k++) begin
      @(posedge clk); #1;
      check("wait_busy", o_busy, 1'b1);
      check("wait_done", o_done, 1'b0);
      req      = 1'b0;
      dev_done = N_DEV'($urandom()) & ~9'h008;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 1'b0);
    check("arst_done", o_done, 1'b0);
    check("arst_data", o_data, 32'h0);
    check("arst_err", o_err, 1'b0);
    check("arst_cause", o_err_cause, 2'b00);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    dev_done = '0;
    @(posedge clk); #1;
    dev_done = 9'h008;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("stale_done", o_done, 1'b0);
      check("stale_busy", o_busy, 1'b0);
      dev_done = '0;
    end

    run_txn(9'h100, 2, 32'h5A5A_0001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
